// File: rtl/fp_writeback_csr_if.sv
// EX-result, Zicsr-access and FP writeback buses of fp_writeback_csr.
// master = pipeline side (drives EX/CSR requests), slave = fp_writeback_csr.
interface fp_writeback_csr_if #(parameter int FLEN = 32);
  logic            i_ex_valid;
  logic [4:0]      i_ex_rd;
  logic            i_ex_fp_reg_write;
  logic            i_ex_is_load;
  logic [FLEN-1:0] i_ex_fp_result;
  logic [4:0]      i_ex_fflags;
  logic            i_csr_en;
  logic [11:0]     i_csr_addr;
  logic [1:0]      i_csr_op;
  logic [31:0]     i_csr_wdata;
  logic            o_csr_hit;
  logic [31:0]     o_csr_rdata;
  logic [4:0]      o_wb_rd;
  logic            o_wb_fp_reg_write;
  logic [FLEN-1:0] o_wb_fp_rd_din;

  modport master (
    output i_ex_valid, i_ex_rd, i_ex_fp_reg_write, i_ex_is_load, i_ex_fp_result, i_ex_fflags,
    output i_csr_en, i_csr_addr, i_csr_op, i_csr_wdata,
    input  o_csr_hit, o_csr_rdata, o_wb_rd, o_wb_fp_reg_write, o_wb_fp_rd_din
  );

  modport slave (
    input  i_ex_valid, i_ex_rd, i_ex_fp_reg_write, i_ex_is_load, i_ex_fp_result, i_ex_fflags,
    input  i_csr_en, i_csr_addr, i_csr_op, i_csr_wdata,
    output o_csr_hit, o_csr_rdata, o_wb_rd, o_wb_fp_reg_write, o_wb_fp_rd_din
  );
endinterface

// File: rtl/fp_writeback_csr.sv
// FP MEM/WB result pipeline, fflags accrual at commit, fcsr ownership and rm resolution.
// Optional macro FP_WB_PERF_CNT_EN adds read-only commit counters at 12'hC20/12'hC21.
module fp_writeback_csr #(
  parameter int          FLEN       = 32,
  parameter logic [11:0] CSR_FFLAGS = 12'h001,
  parameter logic [11:0] CSR_FRM    = 12'h002,
  parameter logic [11:0] CSR_FCSR   = 12'h003
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [FLEN-1:0]     i_mem_load_data,
  input  logic [2:0]          i_instr_rm,
  output logic [2:0]          o_frm,
  output logic                o_frm_illegal,
  output logic [4:0]          o_fflags,
  fp_writeback_csr_if.slave   bus
);

  logic            r_mem_valid, r_mem_wr, r_mem_is_load;
  logic [4:0]      r_mem_rd, r_mem_flags;
  logic [FLEN-1:0] r_mem_result;
  logic            r_wb_valid, r_wb_wr;
  logic [4:0]      r_wb_rd, r_wb_flags;
  logic [FLEN-1:0] r_wb_data;
  logic [2:0]      r_frm;
  logic [4:0]      r_fflags;

  logic        w_commit;
  logic [4:0]  w_acc;
  logic        w_sel_ff, w_sel_frm, w_sel_fcsr, w_sel_cwr, w_sel_cfl, w_csr_wr;
  logic [31:0] w_old, w_new, w_cnt_wr, w_cnt_fl;
  logic        w_unused_new;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_valid   <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_is_load <= 1'b0;
      r_mem_rd      <= '0;
      r_mem_flags   <= '0;
      r_mem_result  <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_wr       <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_flags    <= '0;
      r_wb_data     <= '0;
    end else if (!i_stall) begin
      r_mem_valid   <= bus.i_ex_valid & ~i_flush;
      r_mem_wr      <= bus.i_ex_fp_reg_write;
      r_mem_is_load <= bus.i_ex_is_load;
      r_mem_rd      <= bus.i_ex_rd;
      r_mem_flags   <= bus.i_ex_fflags;
      r_mem_result  <= bus.i_ex_fp_result;
      r_wb_valid    <= r_mem_valid;
      r_wb_wr       <= r_mem_wr;
      r_wb_rd       <= r_mem_rd;
      // Loads raise no FP exceptions; their EX flags are meaningless.
      r_wb_data     <= r_mem_is_load ? i_mem_load_data : r_mem_result;
      r_wb_flags    <= r_mem_is_load ? 5'd0 : r_mem_flags;
    end
  end

  // The WB instruction is older than any CSR access, so its flags land first.
  assign w_commit = r_wb_valid & ~i_stall;
  assign w_acc    = r_fflags | (w_commit ? r_wb_flags : 5'd0);

  assign w_sel_ff   = bus.i_csr_en && (bus.i_csr_addr == CSR_FFLAGS);
  assign w_sel_frm  = bus.i_csr_en && (bus.i_csr_addr == CSR_FRM);
  assign w_sel_fcsr = bus.i_csr_en && (bus.i_csr_addr == CSR_FCSR);
  assign w_csr_wr   = (bus.i_csr_op != 2'b00);

`ifdef FP_WB_PERF_CNT_EN
  logic [31:0] r_cnt_wr, r_cnt_fl;

  assign w_sel_cwr = bus.i_csr_en && (bus.i_csr_addr == 12'hC20);
  assign w_sel_cfl = bus.i_csr_en && (bus.i_csr_addr == 12'hC21);
  assign w_cnt_wr  = r_cnt_wr;
  assign w_cnt_fl  = r_cnt_fl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_wr <= '0;
      r_cnt_fl <= '0;
    end else begin
      if (w_commit && r_wb_wr)     r_cnt_wr <= r_cnt_wr + 32'd1;
      if (w_commit && |r_wb_flags) r_cnt_fl <= r_cnt_fl + 32'd1;
    end
  end
`else
  assign w_sel_cwr = 1'b0;
  assign w_sel_cfl = 1'b0;
  assign w_cnt_wr  = '0;
  assign w_cnt_fl  = '0;
`endif

  always_comb begin
    w_old = '0;
    if (w_sel_ff)   w_old = {27'd0, w_acc};
    if (w_sel_frm)  w_old = {29'd0, r_frm};
    if (w_sel_fcsr) w_old = {24'd0, r_frm, w_acc};
    if (w_sel_cwr)  w_old = w_cnt_wr;
    if (w_sel_cfl)  w_old = w_cnt_fl;
  end

  always_comb begin
    case (bus.i_csr_op)
      2'b01:   w_new = bus.i_csr_wdata;
      2'b10:   w_new = w_old | bus.i_csr_wdata;
      2'b11:   w_new = w_old & ~bus.i_csr_wdata;
      default: w_new = w_old;
    endcase
  end
  assign w_unused_new = ^w_new[31:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fflags <= '0;
      r_frm    <= '0;
    end else begin
      r_fflags <= (w_csr_wr && (w_sel_ff || w_sel_fcsr)) ? w_new[4:0] : w_acc;
      if (w_csr_wr && w_sel_frm)       r_frm <= w_new[2:0];
      else if (w_csr_wr && w_sel_fcsr) r_frm <= w_new[7:5];
    end
  end

  assign bus.o_csr_hit         = w_sel_ff | w_sel_frm | w_sel_fcsr | w_sel_cwr | w_sel_cfl;
  assign bus.o_csr_rdata       = w_old;
  assign bus.o_wb_rd           = r_wb_rd;
  assign bus.o_wb_fp_reg_write = r_wb_valid & r_wb_wr;
  assign bus.o_wb_fp_rd_din    = r_wb_data;
  assign o_fflags              = r_fflags;
  assign o_frm                 = (i_instr_rm == 3'b111) ? r_frm : i_instr_rm;
  assign o_frm_illegal         = (o_frm == 3'b101) || (o_frm == 3'b110) || (o_frm == 3'b111);

endmodule
